wb_master_bridge: RTL and testbench
===================================

// Module: wb_master_bridge
// PURPOSE
//  Wishbone classic single-transfer initiator for the user area. Accepts read/write commands on a
//  valid/ready port and drives wbm_* toward a slave (mprj, uart or decoded wrapper bus). Returns
//  read data and status on a valid/ready response port. Optional bus timeout terminates hung cycles.
// PARAMETERS
//  ADR_W        32    address width
//  DAT_W        32    data width; SEL_W = DAT_W/8
//  TIMEOUT_CYC  255   cycles waiting for wbm_ack_i before abort (WBM_TIMEOUT_EN only), >=1
// PORTS
//  wb_clk_i     in   1      clock, all logic rising edge
//  wb_rst_i     in   1      asynchronous reset, ACTIVE-LOW
//  cmd_valid_i  in   1      command present
//  cmd_ready_o  out  1      bridge can accept command
//  cmd_we_i     in   1      1=write, 0=read
//  cmd_adr_i    in   ADR_W  byte address
//  cmd_dat_i    in   DAT_W  write data
//  cmd_sel_i    in   SEL_W  byte enables
//  rsp_valid_o  out  1      response present
//  rsp_ready_i  in   1      consumer takes response
//  rsp_dat_o    out  DAT_W  read data (0 for writes and timeouts)
//  rsp_err_o    out  1      1=transfer timed out
//  wbm_cyc_o    out  1      Wishbone cycle
//  wbm_stb_o    out  1      Wishbone strobe
//  wbm_we_o     out  1      write enable
//  wbm_sel_o    out  SEL_W  byte select
//  wbm_adr_o    out  ADR_W  address
//  wbm_dat_o    out  DAT_W  write data
//  wbm_ack_i    in   1      slave acknowledge
//  wbm_dat_i    in   DAT_W  slave read data
//  busy_o       out  1      high in BUS or RESP
// BEHAVIOUR
//  - Reset (wb_rst_i=0, async): state=IDLE; all outputs 0 except cmd_ready_o=1; timer=0.
//  - FSM IDLE -> BUS -> RESP -> IDLE; all outputs registered except cmd_ready_o = (state==IDLE).
//  - IDLE: on cmd_valid_i&cmd_ready_o latch we/adr/dat/sel into wbm_* regs; next cycle cyc=stb=1 (BUS).
//  - BUS: cyc/stb/we/sel/adr/dat held stable until termination. On wbm_ack_i=1: drop cyc/stb same
//    edge, capture wbm_dat_i into rsp_dat_o if read (0 if write), rsp_err_o=0, rsp_valid_o=1 -> RESP.
//    Min command-to-response latency: 2 cycles (ack in first BUS cycle).
//  - wbm_ack_i outside BUS ignored (no state change, no data capture).
//  - RESP: rsp_valid_o held with stable dat/err until rsp_ready_i=1; then rsp_valid_o=0 -> IDLE.
//    New command accepted one cycle after response handshake (cmd_ready_o only in IDLE).
//  - wbm_dat_o/adr/sel retain last values after cycle ends; wbm_we_o cleared with cyc.
//  - Reset mid-transfer: cyc/stb drop immediately (async); pending command and response discarded.
//  - Timer: counts BUS cycles, saturating, cleared on entering BUS.
// CONFIGURATION
//  WBM_TIMEOUT_EN defined: if timer reaches TIMEOUT_CYC in BUS without ack, drop cyc/stb,
//   rsp_err_o=1, rsp_dat_o=0, -> RESP. Ack in the same cycle as expiry wins (normal response).
//  Not defined: no timer logic; BUS waits indefinitely for wbm_ack_i; rsp_err_o tied 0.
// TESTING
//  1 write adr=0x3800_0004 dat=0xDEAD_BEEF sel=0xF, ack after 3 cycles -> one cyc/stb window of 3
//    cycles with stable fields, rsp_valid_o with err=0 dat=0, cmd_ready_o low until rsp handshake.
//  2 read adr=0x3000_0000, slave acks in 1st BUS cycle with 0x1234_5678 -> rsp_dat_o=0x1234_5678
//    two cycles after command accept; back-to-back read accepted one cycle after rsp_ready_i.
//  3 rsp_ready_i held low 10 cycles after response -> rsp_valid_o/dat stable, cmd_ready_o=0,
//    cyc=0 throughout; spurious wbm_ack_i pulses in RESP/IDLE change nothing.
//  4 WBM_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> cyc drops after 4 BUS cycles, rsp_err_o=1, dat=0;
//    repeat with ack on expiry cycle -> err=0, data captured. Without macro: cyc stays high 1000 cycles.
//  5 assert wb_rst_i=0 mid-BUS -> cyc/stb/rsp_valid_o 0 asynchronously, cmd_ready_o=1 after release;
//    next command completes normally.

Source files
------------

// File: rtl/wb_master_bridge.sv
// Single-transfer Wishbone classic initiator with valid/ready command and response ports.
// Define WBM_TIMEOUT_EN to abort cycles that are not acknowledged within TIMEOUT_CYC BUS cycles.
module wb_master_bridge #(
  parameter int ADR_W       = 32,
  parameter int DAT_W       = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [ADR_W-1:0]   cmd_adr_i,
  input  logic [DAT_W-1:0]   cmd_dat_i,
  input  logic [DAT_W/8-1:0] cmd_sel_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DAT_W-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [DAT_W-1:0]   wbm_dat_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic               cyc_q;
  logic               stb_q;
  logic               we_q;
  logic [DAT_W/8-1:0] sel_q;
  logic [ADR_W-1:0]   adr_q;
  logic [DAT_W-1:0]   dat_q;
  logic               rsp_valid_q;
  logic [DAT_W-1:0]   rsp_dat_q;
  logic               rsp_err_q;
  logic               busy_q;

  if (TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("wb_master_bridge: TIMEOUT_CYC must be at least 1");
  end

`ifdef WBM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] timer_q;
`endif

  // Transfer sequencer: owns every registered output of the bridge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef WBM_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            state_q <= S_BUS;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= cmd_we_i;
            sel_q   <= cmd_sel_i;
            adr_q   <= cmd_adr_i;
            dat_q   <= cmd_dat_i;
            busy_q  <= 1'b1;
`ifdef WBM_TIMEOUT_EN
            timer_q <= '0;
`endif
          end
        end
        S_BUS: begin
          // Ack takes priority over an expiring timer in the same cycle.
          if (wbm_ack_i) begin
            state_q     <= S_RESP;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= we_q ? '0 : wbm_dat_i;
          end
`ifdef WBM_TIMEOUT_EN
          else if (timer_q >= TMR_W'(TIMEOUT_CYC - 1)) begin
            state_q     <= S_RESP;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_dat_q   <= '0;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          we_q        <= 1'b0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: per-cycle vector table plus hand-written multi-cycle sequences.
// The timeout sequences are built when WBM_TIMEOUT_EN is defined, the no-timeout hold test otherwise.
module tb_wb_master_bridge;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack;
  logic [31:0] wbm_dat_i;
  logic        busy;

  int n_cmp;
  int n_bad;

  wb_master_bridge #(.ADR_W(32), .DAT_W(32), .TIMEOUT_CYC(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .cmd_sel_i  (cmd_sel),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wbm_cyc_o  (wbm_cyc),
    .wbm_stb_o  (wbm_stb),
    .wbm_we_o   (wbm_we),
    .wbm_sel_o  (wbm_sel),
    .wbm_adr_o  (wbm_adr),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_ack_i  (wbm_ack),
    .wbm_dat_i  (wbm_dat_i),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] adat;
    logic        rr;
    logic        e_cyc;
    logic        e_we;
    logic [31:0] e_adr;
    logic [31:0] e_dat;
    logic [3:0]  e_sel;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_rdy;
    logic        e_busy;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic ack, input logic [31:0] adat, input logic rr);
    cmd_valid = v;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    wbm_ack   = ack;
    wbm_dat_i = adat;
    rsp_ready = rr;
  endtask

  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    drive(1'b1, we, adr, dat, sel, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] held;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);

    //              v    we   adr           dat           sel   ack  adat          rr    cyc  we   adr           dat           sel   rv   rd            rdy  busy
    vt[0]  = '{1'b1, 1'b1, 32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,        1'b0, 1'b1};
    vt[1]  = '{1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 4'h1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,        1'b0, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,        1'b0, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'h55AA_55AA, 1'b0, 1'b0, 1'b0, 32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0,        1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0,        1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b0, 32'h0,        1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b1, 32'h1234_5678, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 32'h3000_0008, 32'hBAD0_BAD0, 4'h3, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b0, 32'h0,        1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 32'h3000_0008, 32'h0,         4'h3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h3000_0008, 32'h0,         4'h3, 1'b0, 32'h0,        1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 32'h3000_0008, 32'h0,         4'h3, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h3000_0008, 32'h0,         4'h3, 1'b0, 32'h0,        1'b1, 1'b0};

    repeat (3) tick();
    chk("rst_cyc", {31'h0, wbm_cyc}, 32'h0);
    chk("rst_stb", {31'h0, wbm_stb}, 32'h0);
    chk("rst_rdy", {31'h0, cmd_ready}, 32'h1);
    chk("rst_rv", {31'h0, rsp_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rdat", rsp_dat, 32'h0);
    chk("rst_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_adr", wbm_adr, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rdy", {31'h0, cmd_ready}, 32'h1);

    // Write with 3-cycle ack, then read with first-cycle ack and a back-to-back read.
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].v, vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, vt[i].ack, vt[i].adat, vt[i].rr);
      tick();
      chk($sformatf("v%0d_cyc", i), {31'h0, wbm_cyc}, {31'h0, vt[i].e_cyc});
      chk($sformatf("v%0d_stb", i), {31'h0, wbm_stb}, {31'h0, vt[i].e_cyc});
      chk($sformatf("v%0d_we", i), {31'h0, wbm_we}, {31'h0, vt[i].e_we});
      chk($sformatf("v%0d_adr", i), wbm_adr, vt[i].e_adr);
      chk($sformatf("v%0d_dat", i), wbm_dat_o, vt[i].e_dat);
      chk($sformatf("v%0d_sel", i), {28'h0, wbm_sel}, {28'h0, vt[i].e_sel});
      chk($sformatf("v%0d_rv", i), {31'h0, rsp_valid}, {31'h0, vt[i].e_rv});
      chk($sformatf("v%0d_rdy", i), {31'h0, cmd_ready}, {31'h0, vt[i].e_rdy});
      chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, vt[i].e_busy});
      if (vt[i].e_rv) begin
        chk($sformatf("v%0d_rdat", i), rsp_dat, vt[i].e_rd);
        chk($sformatf("v%0d_err", i), {31'h0, rsp_err}, 32'h0);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);

    // Response back-pressure with spurious acks in RESP, then in IDLE.
    send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    wbm_ack = 1'b1; wbm_dat_i = 32'hA5A5_0001;
    tick();
    for (int i = 0; i < 10; i++) begin
      wbm_ack   = i[0];
      wbm_dat_i = 32'h0F0F_0000 + i;
      tick();
      chk("bp_rv", {31'h0, rsp_valid}, 32'h1);
      chk("bp_rdat", rsp_dat, 32'hA5A5_0001);
      chk("bp_rdy", {31'h0, cmd_ready}, 32'h0);
      chk("bp_cyc", {31'h0, wbm_cyc}, 32'h0);
    end
    wbm_ack = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wbm_ack = 1'b1; wbm_dat_i = 32'h7777_0000 + i;
      tick();
      chk("idle_ack_cyc", {31'h0, wbm_cyc}, 32'h0);
      chk("idle_ack_rv", {31'h0, rsp_valid}, 32'h0);
      chk("idle_ack_rdy", {31'h0, cmd_ready}, 32'h1);
      chk("idle_ack_busy", {31'h0, busy}, 32'h0);
    end
    wbm_ack = 1'b0;

`ifdef WBM_TIMEOUT_EN
    // No ack: four BUS cycles then an error response with zero data.
    send(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk("to_cyc_hold", {31'h0, wbm_cyc}, 32'h1);
      tick();
    end
    chk("to_cyc_last", {31'h0, wbm_cyc}, 32'h1);
    tick();
    chk("to_cyc_drop", {31'h0, wbm_cyc}, 32'h0);
    chk("to_rv", {31'h0, rsp_valid}, 32'h1);
    chk("to_err", {31'h0, rsp_err}, 32'h1);
    chk("to_rdat", rsp_dat, 32'h0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    // Ack arriving on the expiry cycle wins.
    send(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    repeat (3) tick();
    wbm_ack = 1'b1; wbm_dat_i = 32'hBEEF_0042;
    tick();
    wbm_ack = 1'b0;
    chk("toack_rv", {31'h0, rsp_valid}, 32'h1);
    chk("toack_err", {31'h0, rsp_err}, 32'h0);
    chk("toack_rdat", rsp_dat, 32'hBEEF_0042);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
`else
    // Without the timeout the cycle is held indefinitely.
    send(1'b1, 32'h3000_0020, 32'h0000_0099, 4'hF);
    for (int i = 0; i < 1000; i++) begin
      tick();
      chk("hold_cyc", {31'h0, wbm_cyc}, 32'h1);
    end
    chk("hold_err", {31'h0, rsp_err}, 32'h0);
    wbm_ack = 1'b1; tick(); wbm_ack = 1'b0;
    chk("hold_end_rv", {31'h0, rsp_valid}, 32'h1);
    chk("hold_end_err", {31'h0, rsp_err}, 32'h0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
`endif

    // Asynchronous reset in the middle of BUS.
    send(1'b1, 32'h3000_0030, 32'h1111_2222, 4'hF);
    chk("mid_pre_cyc", {31'h0, wbm_cyc}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'h0, wbm_cyc}, 32'h0);
    chk("mid_rst_stb", {31'h0, wbm_stb}, 32'h0);
    chk("mid_rst_rv", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_rdy", {31'h0, cmd_ready}, 32'h1);
    chk("mid_rel_cyc", {31'h0, wbm_cyc}, 32'h0);

    // Asynchronous reset while a response is waiting.
    send(1'b0, 32'h3000_0034, 32'h0, 4'hF);
    wbm_ack = 1'b1; wbm_dat_i = 32'h0000_ABCD; tick(); wbm_ack = 1'b0;
    chk("resp_pre_rv", {31'h0, rsp_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("resp_rst_rv", {31'h0, rsp_valid}, 32'h0);
    chk("resp_rst_rdat", rsp_dat, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Next command after reset completes normally.
    send(1'b0, 32'h3000_0038, 32'h0, 4'h3);
    chk("after_adr", wbm_adr, 32'h3000_0038);
    chk("after_sel", {28'h0, wbm_sel}, 32'h3);
    wbm_ack = 1'b1; wbm_dat_i = 32'h600D_CAFE; tick(); wbm_ack = 1'b0;
    chk("after_rv", {31'h0, rsp_valid}, 32'h1);
    chk("after_rdat", rsp_dat, 32'h600D_CAFE);
    chk("after_err", {31'h0, rsp_err}, 32'h0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("after_rdy", {31'h0, cmd_ready}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
